// File: rtl/lfsr_multimode.sv
// LFSR engine, Fibonacci or Galois, runtime poly/seed, up to STEP_MAX steps per clock.
// Latency: a run of N steps finishes in ceil(N/STEP_MAX) cycles after the START edge; load is 1 cycle.
// Backpressure: none; START is dropped while busy or locked up, LOAD always wins and aborts a run.
module lfsr_multimode #(
  parameter int W        = 8,   // state width, >= 2
  parameter int STEP_MAX = 4,   // steps per clock, 1..W
  parameter int CW       = 16   // step-count width
) (
  input  logic                CLK_I,
  input  logic                RST_N_I,
  input  logic                LOAD_I,
  input  logic                MODE_I,
  input  logic [W-1:0]        POLY_I,
  input  logic [W-1:0]        SEED_I,
  input  logic                START_I,
  input  logic [CW-1:0]       STEPS_I,
  output logic                BUSY_O,
  output logic                DONE_O,
  output logic [W-1:0]        DATA_O,
  output logic [STEP_MAX-1:0] BITS_O,
  output logic                LOCKUP_O
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  localparam logic [CW-1:0] STEP_MAX_CW = CW'(STEP_MAX);

  fsm_t                fsm_q, fsm_d;
  logic [W-1:0]        poly_q, poly_d;
  logic                mode_q, mode_d;
  logic [W-1:0]        lfsr_q, lfsr_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [STEP_MAX-1:0] bits_q, bits_d;
  logic                done_q, done_d;

  logic [CW-1:0]       chunk_len;
  logic [W-1:0]        chunk_state;
  logic [STEP_MAX-1:0] chunk_bits;
  logic                lockup;

  // Single LFSR step; the shifted-out bit is always the MSB in both modes.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s,
                                             input logic [W-1:0] p,
                                             input logic         m);
    if (m) begin
      return {s[W-2:0], 1'b0} ^ (s[W-1] ? p : '0);
    end
    return {s[W-2:0], ^(s & p)};
  endfunction

  assign lockup = (lfsr_q == '0);

  // Unrolled chain: steps past the current chunk length pass the state through and emit 0.
  always_comb begin
    chunk_len   = (rem_q > STEP_MAX_CW) ? STEP_MAX_CW : rem_q;
    chunk_state = lfsr_q;
    chunk_bits  = '0;
    for (int j = 0; j < STEP_MAX; j++) begin
      if (CW'(j) < chunk_len) begin
        chunk_bits[j] = chunk_state[W-1];
        chunk_state   = lfsr_step(chunk_state, poly_q, mode_q);
      end
    end
  end

  // Next-state logic: LOAD aborts anything, START only acts in IDLE with a live state.
  always_comb begin
    fsm_d  = fsm_q;
    poly_d = poly_q;
    mode_d = mode_q;
    lfsr_d = lfsr_q;
    rem_d  = rem_q;
    bits_d = bits_q;
    done_d = 1'b0;
    if (LOAD_I) begin
      fsm_d  = IDLE;
      poly_d = POLY_I;
      mode_d = MODE_I;
      lfsr_d = SEED_I;
      rem_d  = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (START_I && !lockup) begin
            if (STEPS_I == '0) begin
              done_d = 1'b1;
            end else begin
              rem_d = STEPS_I;
              fsm_d = RUN;
            end
          end
        end
        RUN: begin
          lfsr_d = chunk_state;
          bits_d = chunk_bits;
          rem_d  = rem_q - chunk_len;
          if (rem_q <= STEP_MAX_CW) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      fsm_q  <= IDLE;
      poly_q <= '0;
      mode_q <= 1'b0;
      lfsr_q <= '0;
      rem_q  <= '0;
      bits_q <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      poly_q <= poly_d;
      mode_q <= mode_d;
      lfsr_q <= lfsr_d;
      rem_q  <= rem_d;
      bits_q <= bits_d;
      done_q <= done_d;
    end
  end

  assign BUSY_O   = (fsm_q == RUN);
  assign DONE_O   = done_q;
  assign DATA_O   = lfsr_q;
  assign BITS_O   = bits_q;
  assign LOCKUP_O = lockup;

endmodule

// File: tb/tb_lfsr_multimode.sv
// Randomized self-checking bench for lfsr_multimode against an arithmetic reference model.
// Latency: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: none; START pokes during a run are expected to be ignored.
module tb_lfsr_multimode;

  localparam int W    = 8;
  localparam int SM   = 4;
  localparam int CW   = 16;
  localparam int MASK = (1 << W) - 1;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic          mode_in;
  logic [W-1:0]  poly_in;
  logic [W-1:0]  seed_in;
  logic          start;
  logic [CW-1:0] steps_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  data;
  logic [SM-1:0] bits_o;
  logic          lockup;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state = 0;
  int m_poly  = 0;
  int m_mode  = 0;

  lfsr_multimode #(.W(W), .STEP_MAX(SM), .CW(CW)) dut (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .LOAD_I  (load),
    .MODE_I  (mode_in),
    .POLY_I  (poly_in),
    .SEED_I  (seed_in),
    .START_I (start),
    .STEPS_I (steps_in),
    .BUSY_O  (busy),
    .DONE_O  (done),
    .DATA_O  (data),
    .BITS_O  (bits_o),
    .LOCKUP_O(lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One step computed with plain arithmetic on integers.
  function automatic int ref_step(input int s, input int p, input int md);
    int msb;
    msb = (s >> (W - 1)) & 1;
    if (md == 0) return ((s << 1) | ($countones(s & p) % 2)) & MASK;
    return ((s << 1) & MASK) ^ (msb != 0 ? p : 0);
  endfunction

  // Advance the model by k steps, returning the emitted bits (oldest at bit 0).
  task automatic model_chunk(input int k, output int bits);
    bits = 0;
    for (int j = 0; j < k; j++) begin
      bits = bits | (((m_state >> (W - 1)) & 1) << j);
      m_state = ref_step(m_state, m_poly, m_mode);
    end
  endtask

  task automatic do_load(input int md, input int p, input int sd);
    @(negedge clk);
    load    = 1'b1;
    mode_in = md[0];
    poly_in = W'(p);
    seed_in = W'(sd);
    @(posedge clk); #1;
    load    = 1'b0;
    m_mode  = md;
    m_poly  = p;
    m_state = sd;
    check("load_data", data, sd);
    check("load_busy", busy, 0);
    check("load_done", done, 0);
    check("load_lockup", lockup, (sd == 0));
  endtask

  // Issue START with a step count and follow every chunk; optionally poke START mid-run.
  task automatic do_run(input int steps, input bit poke);
    int rem, k, bits;
    @(negedge clk);
    start    = 1'b1;
    steps_in = CW'(steps);
    @(posedge clk); #1;
    start = 1'b0;
    if (m_state == 0) begin
      check("lock_busy", busy, 0);
      @(posedge clk); #1;
      check("lock_done", done, 0);
      check("lock_data", data, 0);
      return;
    end
    if (steps == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_data", data, m_state);
      return;
    end
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_data", data, m_state);
    rem = steps;
    while (rem > 0) begin
      if (poke) begin
        start    = 1'b1;
        steps_in = CW'($urandom_range(1, 50));
      end
      @(posedge clk); #1;
      start = 1'b0;
      k = (rem < SM) ? rem : SM;
      model_chunk(k, bits);
      rem -= k;
      check("chunk_data", data, m_state);
      check("chunk_bits", bits_o, bits);
      check("chunk_busy", busy, (rem > 0));
      check("chunk_done", done, (rem == 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bits;
    rst_n    = 1'b1;
    load     = 1'b0;
    mode_in  = 1'b0;
    poly_in  = '0;
    seed_in  = '0;
    start    = 1'b0;
    steps_in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bits", bits_o, 0);
    check("rst_lockup", lockup, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fibonacci single steps, then a full period
    do_load(0, 'hB8, 'h01);
    do_run(1, 0); check("fib_s1", data, 'h02);
    do_run(1, 0); check("fib_s2", data, 'h04);
    do_run(1, 0); check("fib_s3", data, 'h08);
    do_run(1, 0); check("fib_s4", data, 'h11);
    do_load(0, 'hB8, 'h01);
    do_run(4, 0); check("fib_4step", data, 'h11);
    do_run(255 - 4, 0);
    do_load(0, 'hB8, 'h01);
    do_run(255, 0); check("fib_period", data, 'h01);

    // Galois
    do_load(1, 'h1D, 'h80);
    do_run(1, 0); check("gal_s1", data, 'h1D); check("gal_bit0", bits_o[0], 1);
    do_run(1, 0); check("gal_s2", data, 'h3A);
    do_load(1, 'h1D, 'h80);
    do_run(255, 0); check("gal_period", data, 'h80);

    // Multi-step chunking 4,4,2
    do_load(0, 'hB8, 'h5A);
    do_run(10, 0);
    check("ms_bits_hi", bits_o[3:2], 0);

    // Lock-up handling
    do_load(0, 'hB8, 'h00);
    do_run(5, 0);
    do_run(0, 0);
    do_load(0, 'hB8, 'h01);
    check("unlock", lockup, 0);

    // STEPS = 0 and DONE pulse width
    do_run(0, 0);
    @(posedge clk); #1;
    check("zero_pulse", done, 0);
    check("zero_keep", data, m_state);

    // Back-to-back runs and START during RUN
    do_run(6, 0);
    do_run(3, 0);
    do_run(13, 1);
    @(posedge clk); #1;
    check("poke_idle", busy, 0);
    check("poke_pulse", done, 0);

    // Abort with LOAD mid-run
    do_load(0, 'hB8, 'h5A);
    @(negedge clk);
    start = 1'b1; steps_in = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy", busy, 1);
    repeat (3) begin
      @(posedge clk); #1;
      model_chunk(SM, bits);
      check("abort_data", data, m_state);
      check("abort_bits", bits_o, bits);
    end
    do_load(1, 'h1D, 'h33);
    @(posedge clk); #1;
    check("abort_nodone", done, 0);
    check("abort_idle", busy, 0);

    // Asynchronous reset mid-run
    do_load(1, 'h1D, 'h80);
    @(negedge clk);
    start = 1'b1; steps_in = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_data", data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_bits", bits_o, 0);
    check("arst_lockup", lockup, 1);
    m_state = 0; m_poly = 0; m_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_nodone", done, 0);
    check("arst_idle", busy, 0);

    // Randomized loads and runs
    do_load(0, 'hB8, 'h01);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_load(int'($urandom_range(0, 1)), int'($urandom_range(0, MASK)),
                ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, MASK)));
      end
      do_run(int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_multimode.md
# lfsr_multimode

Parametrised LFSR engine that supports both Fibonacci and Galois mode, with runtime polynomial, seed and step count. Each cycle it advances up to STEP_MAX steps through an unrolled chain, so a request of N steps completes in ceil(N/STEP_MAX) cycles. It reports completion with a done pulse and flags the all-zero lock-up state. It sits in the ASIC_design LFSR library as the general-purpose successor to the single-mode Fibonacci register, feeding scramblers, BIST pattern generators and CRC-style checkers.

## Interface
- W, 8: LFSR state width, minimum 2.
- STEP_MAX, 4: maximum LFSR steps advanced per clock, range 1..W.
- CW, 16: width of the step-count request.

- CLK_I  in  1  clock; all state changes on the rising edge.
- RST_N_I  in  1  reset, asynchronous, active-low.
- LOAD_I  in  1  load POLY_I, SEED_I and MODE_I into internal registers.
- MODE_I  in  1  0 = Fibonacci, 1 = Galois; sampled on LOAD_I only.
- POLY_I  in  W  tap mask; bit i set means state bit i is a tap.
- SEED_I  in  W  initial state.
- START_I  in  1  start request of STEPS_I steps.
- STEPS_I  in  CW  number of steps to advance; sampled with START_I.
- BUSY_O  out  1  run in progress.
- DONE_O  out  1  one-cycle pulse when a run completes.
- DATA_O  out  W  current LFSR state.
- BITS_O  out  STEP_MAX  serial output bits of the last chunk; bit 0 is the oldest.
- LOCKUP_O  out  1  high whenever the state is all-zero.

## Operation
- Registers: poly, mode, state, remaining step count (CW bits), busy.
- One step in Fibonacci mode:
  - out = s[W-1]
  - fb = ^(s & poly)
  - s' = {s[W-2:0], fb}
- One step in Galois mode:
  - out = s[W-1]
  - s' = {s[W-2:0], 1'b0} ^ (out ? poly : 0)
- Chunk size per cycle: k = min(remaining, STEP_MAX). The state advances k chained steps in one clock.
  - BITS_O[j] holds the out bit of step j of the chunk, for j < k.
  - BITS_O[j] = 0 for j >= k.
- FSM has two states, IDLE and RUN.
- IDLE:
  - START_I with STEPS_I > 0 and LOCKUP_O = 0 loads remaining = STEPS_I and moves to RUN.
  - START_I with STEPS_I = 0 pulses DONE_O the next cycle and leaves the state unchanged.
  - START_I while LOCKUP_O = 1 is ignored: no DONE_O and no change.
- RUN:
  - Each cycle, advance k steps and set remaining -= k.
  - When remaining reaches 0, return to IDLE and pulse DONE_O.
- Priority: reset > LOAD_I > START_I.
  - LOAD_I in RUN aborts the run: go to IDLE with no DONE_O, then load the registers.
  - START_I while in RUN is ignored.
- LOCKUP_O = (state == 0), combinational from the state register.
- Loading SEED_I = 0 raises LOCKUP_O immediately after the load edge.
- A zero state is a fixed point of both step functions. A run that reaches zero continues to its end, and the state stays 0.
- POLY_I = 0 is legal:
  - Fibonacci mode shifts zeros in.
  - Galois mode degenerates to a plain shift.

## Timing
- Reset values:
  - state = 0, poly = 0, mode = 0, remaining = 0.
  - BUSY_O = 0, DONE_O = 0, BITS_O = 0, DATA_O = 0.
  - LOCKUP_O = 1.
- LOAD_I at edge n: DATA_O = SEED_I from edge n.
- START_I at edge n with STEPS_I = N > 0:
  - BUSY_O = 1 from edge n.
  - The first chunk is applied at edge n+1.
  - The last chunk is applied at edge n + ceil(N/STEP_MAX).
  - On that same edge BUSY_O falls and DONE_O rises, lasting one cycle.
- DATA_O and BITS_O update on the same edge as each chunk. BITS_O holds its value between chunks.
- Back-to-back runs: START_I is accepted in the cycle DONE_O is high, because the FSM is already in IDLE.
- Reset asserted mid-run clears everything asynchronously and produces no DONE_O.

## Test plan
- Fibonacci, STEP_MAX = 1: load POLY = 0xB8, SEED = 0x01, then START with 4 steps.
  - DATA_O sequence: 0x02, 0x04, 0x08, 0x11.
  - DONE_O pulses after the 4th step.
  - A 255-step run returns DATA_O to 0x01.
- Galois: load POLY = 0x1D, SEED = 0x80, MODE = 1, then START with 1 step.
  - DATA_O = 0x1D, BITS_O[0] = 1.
  - The next single step gives 0x3A.
  - A 255-step run returns to 0x80.
- Multi-step, STEP_MAX = 4, STEPS = 10:
  - BUSY_O is high for 3 chunk cycles with chunks of 4, 4 and 2.
  - Final DATA_O equals the 10-step reference model.
  - BITS_O[3:2] = 0 on the last chunk.
- Lock-up:
  - Load SEED = 0: LOCKUP_O = 1, and START is ignored (no BUSY_O, no DONE_O).
  - Reloading SEED = 0x01 clears LOCKUP_O.
  - Check LOCKUP_O = 1 out of reset.
- Abort and reset:
  - LOAD_I during a 100-step run: BUSY_O drops, no DONE_O, DATA_O = new seed.
  - Asynchronous reset mid-run: all outputs go to their reset values immediately.
- Edge cases:
  - STEPS = 0 gives DONE_O one cycle later with DATA_O unchanged.
  - START during RUN is ignored.
  - START in the DONE_O cycle is accepted.
